mainfsm_ext: RTL and testbench

- Next-generation main control FSM for the multi-cycle RV32I core; drives the same datapath control bus as the current main FSM.
- Adds a memory ready/request handshake with wait states and optional timeout, plus support for jalr, lui, auipc, all branch opcodes and fence-as-NOP.
- Adds a sticky trap state for illegal opcodes and bus timeouts.
- Sits beside the ALU decoder and branch-condition logic in the controller.

---
 rtl/mainfsm_ext.sv | 186 ++++++++++++++++++
 tb/tb_mainfsm_ext.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mainfsm_ext.sv
// mainfsm_ext: multi-cycle RV32I main control FSM with memory handshake, timeout and sticky trap
// Optional feature macro: MAINFSM_PERF_EN (adds cycle_cnt / instret_cnt outputs)
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   op                opcode from the instruction register
//   MemReady          memory completes the current access this cycle
//   MemReq            memory request, held until MemReady
//   RegWrite, MemWrite, IRWrite, Branch, PCUpdate   datapath enables
//   ALUSrcA, ALUSrcB, AdrSrc, ResultSrc, ALUOp      datapath selects
//   Illegal, BusErr   sticky trap flag / trap caused by bus timeout
//   state_o           current state for debug
//   cycle_cnt, instret_cnt   performance counters (MAINFSM_PERF_EN only)
module mainfsm_ext #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       Branch,
    output logic       PCUpdate,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic       Illegal,
    output logic       BusErr,
    output logic [3:0] state_o
`ifdef MAINFSM_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
        JAL = 4'd10, JALRADR = 4'd11, LUI = 4'd12, TRAP = 4'd15
    } state_t;
    // wait count never exceeds MEM_TIMEOUT-1: the limit cycle either completes or traps
    localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    state_t state, state_n;
    logic [WW-1:0] wcnt;
    logic waiting, tmo;
    assign waiting = state == FETCH || state == MEMRD || state == MEMWR;
    assign tmo = MEM_TIMEOUT != 0 && waiting && !MemReady && 32'(wcnt) + 32'd1 >= 32'(MEM_TIMEOUT);
    assign state_o = state;
    assign Illegal = state == TRAP;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            wcnt <= '0;
            BusErr <= 1'b0;
        end else begin
            state <= state_n;
            wcnt <= (waiting && !MemReady && state_n == state) ? wcnt + 1'b1 : '0;
            if (tmo) BusErr <= 1'b1;
        end
    end
    always_comb begin
        state_n = TRAP;
        MemReq = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        IRWrite = 1'b0;
        Branch = 1'b0;
        PCUpdate = 1'b0;
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b00;
        AdrSrc = 1'b0;
        ResultSrc = 2'b00;
        ALUOp = 2'b00;
        case (state)
            FETCH: begin
                MemReq = 1'b1;
                IRWrite = MemReady;
                PCUpdate = MemReady;
                ALUSrcB = 2'b10;
                ResultSrc = 2'b10;
                state_n = MemReady ? DECODE : tmo ? TRAP : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_n = MEMADR;
                    7'b0110011: state_n = EXECUTER;
                    7'b0010011: state_n = EXECUTEI;
                    7'b1100011: state_n = BRANCH;
                    7'b1101111: state_n = JAL;
                    7'b1100111: state_n = JALRADR;
                    7'b0110111: state_n = LUI;
                    7'b0010111: state_n = ALUWB;
                    7'b0001111: state_n = FETCH;
                    default: state_n = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_n = op == 7'b0100011 ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                state_n = MemReady ? MEMWB : tmo ? TRAP : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                ResultSrc = 2'b01;
                state_n = FETCH;
            end
            MEMWR: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                MemWrite = MemReady;
                state_n = MemReady ? FETCH : tmo ? TRAP : MEMWR;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp = 2'b10;
                state_n = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp = 2'b10;
                state_n = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_n = FETCH;
            end
            BRANCH: begin
                Branch = 1'b1;
                ALUSrcA = 2'b10;
                ALUOp = 2'b01;
                state_n = FETCH;
            end
            JALRADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_n = JAL;
            end
            JAL: begin
                PCUpdate = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_n = ALUWB;
            end
            LUI: begin
                RegWrite = 1'b1;
                ResultSrc = 2'b11;
                state_n = FETCH;
            end
            default: state_n = TRAP;
        endcase
        if (reset) begin
            MemReq = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            IRWrite = 1'b0;
            Branch = 1'b0;
            PCUpdate = 1'b0;
        end
    end
`ifdef MAINFSM_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != TRAP) cycle_cnt <= cycle_cnt + 1'b1;
            if (state_n == FETCH && state != FETCH) instret_cnt <= instret_cnt + 1'b1;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_mainfsm_ext.sv
// tb_mainfsm_ext: directed scoreboard bench for mainfsm_ext
module tb_mainfsm_ext;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADD = 7'b0110011, ADDI = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011, JALI = 7'b1101111, JALR = 7'b1100111, LUII = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111, FENCE = 7'b0001111, BAD = 7'b1111111;
    typedef struct {
        int id;
        logic [20:0] v;
    } exp_t;
    logic clk = 1'b0, reset = 1'b1, MemReady = 1'b0;
    logic [6:0] op = 7'd0;
    logic MemReq, RegWrite, MemWrite, IRWrite, Branch, PCUpdate, AdrSrc, Illegal, BusErr;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
    logic [3:0] state_o;
`ifdef MAINFSM_PERF_EN
    logic [3:0] cycle_cnt, instret_cnt;
`endif
    exp_t exp_q[$];
    int total = 0, bad = 0, nstep = 0;

    mainfsm_ext #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
        .MemReq(MemReq), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .Branch(Branch), .PCUpdate(PCUpdate), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .Illegal(Illegal),
        .BusErr(BusErr), .state_o(state_o)
`ifdef MAINFSM_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {MemReq,RegWrite,MemWrite,IRWrite,Branch,PCUpdate,AdrSrc,A,B,Res,Op,Illegal,BusErr}
    function automatic logic [16:0] exp_vec(input logic [3:0] s, input logic m, input logic r, input logic be);
        logic [5:0] en;
        logic ad, il;
        logic [1:0] a, b, res, alu;
        en = 6'd0; ad = 1'b0; il = 1'b0; a = 2'd0; b = 2'd0; res = 2'd0; alu = 2'd0;
        case (s)
            4'd0: begin en = {1'b1, 2'b00, m, 1'b0, m}; b = 2'd2; res = 2'd2; end
            4'd1: begin a = 2'd1; b = 2'd1; end
            4'd2: begin a = 2'd2; b = 2'd1; end
            4'd3: begin en = 6'b100000; ad = 1'b1; end
            4'd4: begin en = 6'b010000; res = 2'd1; end
            4'd5: begin en = {2'b10, m, 3'b000}; ad = 1'b1; end
            4'd6: begin a = 2'd2; alu = 2'd2; end
            4'd7: begin a = 2'd2; b = 2'd1; alu = 2'd2; end
            4'd8: en = 6'b010000;
            4'd9: begin en = 6'b000010; a = 2'd2; alu = 2'd1; end
            4'd10: begin en = 6'b000001; a = 2'd1; b = 2'd2; end
            4'd11: begin a = 2'd2; b = 2'd1; end
            4'd12: begin en = 6'b010000; res = 2'd3; end
            default: il = 1'b1;
        endcase
        if (r) en = 6'd0;
        return {en, ad, a, b, res, alu, il, be};
    endfunction

    task automatic step(input logic [6:0] o, input logic m, input logic r, input logic [3:0] es, input logic be);
        exp_t e;
        @(posedge clk);
        #1;
        op = o;
        MemReady = m;
        reset = r;
        nstep++;
        e.id = nstep;
        e.v = {es, exp_vec(es, m, r, be)};
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [20:0] act;
            e = exp_q.pop_front();
            act = {state_o, MemReq, RegWrite, MemWrite, IRWrite, Branch, PCUpdate, AdrSrc,
                   ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Illegal, BusErr};
            total++;
            if (act !== e.v) begin
                bad++;
                $display("FAIL step%0d: got state=%0d ctl=%b expected state=%0d ctl=%b",
                         e.id, act[20:17], act[16:0], e.v[20:17], e.v[16:0]);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        step(ADD, 1, 1, 0, 0);
        step(ADD, 1, 0, 0, 0); step(ADD, 1, 0, 1, 0); step(ADD, 1, 0, 6, 0); step(ADD, 1, 0, 8, 0);
        step(LW, 1, 0, 0, 0); step(LW, 1, 0, 1, 0); step(LW, 1, 0, 2, 0);
        step(LW, 0, 0, 3, 0); step(LW, 0, 0, 3, 0); step(LW, 0, 0, 3, 0); step(LW, 1, 0, 3, 0);
        step(LW, 1, 0, 4, 0);
        step(SW, 1, 0, 0, 0); step(SW, 1, 0, 1, 0); step(SW, 1, 0, 2, 0);
        step(SW, 0, 0, 5, 0); step(SW, 1, 0, 5, 0);
        step(ADDI, 1, 0, 0, 0); step(ADDI, 1, 0, 1, 0); step(ADDI, 1, 0, 7, 0); step(ADDI, 1, 0, 8, 0);
        step(BEQ, 1, 0, 0, 0); step(BEQ, 1, 0, 1, 0); step(BEQ, 1, 0, 9, 0);
        step(JALI, 1, 0, 0, 0); step(JALI, 1, 0, 1, 0); step(JALI, 1, 0, 10, 0); step(JALI, 1, 0, 8, 0);
        step(JALR, 1, 0, 0, 0); step(JALR, 1, 0, 1, 0); step(JALR, 1, 0, 11, 0);
        step(JALR, 1, 0, 10, 0); step(JALR, 1, 0, 8, 0);
        step(LUII, 1, 0, 0, 0); step(LUII, 1, 0, 1, 0); step(LUII, 1, 0, 12, 0);
        step(AUIPC, 1, 0, 0, 0); step(AUIPC, 1, 0, 1, 0); step(AUIPC, 1, 0, 8, 0);
        step(FENCE, 1, 0, 0, 0); step(FENCE, 1, 0, 1, 0);
        // ready arrives exactly on the limit cycle: completes normally
        step(FENCE, 0, 0, 0, 0); step(FENCE, 0, 0, 0, 0); step(FENCE, 0, 0, 0, 0);
        step(FENCE, 1, 0, 0, 0); step(FENCE, 1, 0, 1, 0);
        step(BAD, 1, 0, 0, 0); step(BAD, 1, 0, 1, 0);
        for (int i = 0; i < 20; i++) step(BAD, i[0], 0, 15, 0);
        step(BAD, 1, 1, 15, 0);
        step(ADD, 1, 0, 0, 0); step(ADD, 1, 0, 1, 0); step(ADD, 1, 1, 6, 0);
        for (int i = 0; i < 4; i++) step(ADD, 0, 0, 0, 0);
        step(ADD, 0, 0, 15, 1); step(ADD, 1, 0, 15, 1);
        step(ADD, 0, 1, 15, 1);
        step(ADD, 1, 0, 0, 0);
`ifdef MAINFSM_PERF_EN
        step(ADD, 1, 0, 1, 0);
        chk("cycle_cnt_1", int'(cycle_cnt), 1);
        step(ADD, 1, 0, 6, 0); step(ADD, 1, 0, 8, 0);
        for (int i = 0; i < 3; i++) begin
            step(ADD, 1, 0, 0, 0); step(ADD, 1, 0, 1, 0); step(ADD, 1, 0, 6, 0); step(ADD, 1, 0, 8, 0);
        end
        step(ADD, 1, 0, 0, 0);
        chk("cycle_cnt_wrap", int'(cycle_cnt), 0);
        chk("instret_4", int'(instret_cnt), 4);
        step(ADD, 1, 0, 1, 0);
        chk("cycle_cnt_17", int'(cycle_cnt), 1);
        step(ADD, 1, 1, 6, 0);
        chk("cycle_cnt_pre_rst", int'(cycle_cnt), 2);
        step(ADD, 1, 0, 0, 0);
        chk("cycle_cnt_rst", int'(cycle_cnt), 0);
        chk("instret_rst", int'(instret_cnt), 0);
`endif
        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
